// File: rtl/quad_decoder_if.sv
// ---------------------------------------------------------------------------
// quad_decoder_if
//
// Purpose:
//    Bundles the quadrature decoder's pin-side inputs and its step/direction
//    and position outputs. The decoder is the producing end of the enable /
//    up-down link that the up/down counters consume.
//
// Signals:
//    enc_a, enc_b  encoder phases A and B, asynchronous to clk
//    clr           synchronous position clear
//    err_clr       clears the sticky illegal-transition flag
//    step          one-cycle pulse per accepted legal transition
//    dir           1 = up, 0 = down; valid with step, holds otherwise
//    position      accumulated count, modulo 2^CNT_W
//    err           sticky illegal-transition flag
//
// Modports:
//    master  the decoder itself (consumes pins/controls, drives results)
//    slave   the surrounding logic (drives pins/controls, reads results)
// ---------------------------------------------------------------------------
interface quad_decoder_if #(
   parameter int CNT_W = 16
);

   logic             enc_a;
   logic             enc_b;
   logic             clr;
   logic             err_clr;
   logic             step;
   logic             dir;
   logic [CNT_W-1:0] position;
   logic             err;

   modport master (
      input  enc_a,
      input  enc_b,
      input  clr,
      input  err_clr,
      output step,
      output dir,
      output position,
      output err
   );

   modport slave (
      output enc_a,
      output enc_b,
      output clr,
      output err_clr,
      input  step,
      input  dir,
      input  position,
      input  err
   );

endinterface

// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
//
// Purpose:
//    Quadrature encoder front end. Synchronizes the asynchronous A/B phases,
//    debounces the 2-bit phase vector, and turns each accepted legal
//    transition into a single-cycle step pulse with a direction flag. Keeps
//    a wrapping position count and a sticky flag for illegal transitions
//    (both phases changing at once).
//
// Parameters:
//    CNT_W     width of the position counter
//    FILT_LEN  consecutive stable synchronized samples needed to accept a
//              new AB state (1..15)
//
// Ports:
//    clk   system clock
//    rst   synchronous, active-high reset
//    bus   quad_decoder_if master modport (enc_a, enc_b, clr, err_clr in;
//          step, dir, position, err out)
// ---------------------------------------------------------------------------
module quad_decoder #(
   parameter int CNT_W    = 16,
   parameter int FILT_LEN = 3
) (
   input  logic           clk,
   input  logic           rst,
   quad_decoder_if.master bus
);

   localparam logic [3:0]       FILT_MAX = 4'(FILT_LEN);
   localparam logic [CNT_W-1:0] POS_ONE  = 1;

   logic [1:0]       sync1;
   logic [1:0]       sync2;
   logic [1:0]       cand;
   logic [1:0]       filt;
   logic [3:0]       stable_cnt;
   logic             primed;

   logic             step_q;
   logic             dir_q;
   logic             err_q;
   logic [CNT_W-1:0] pos_q;

   logic             qualify;
   logic [1:0]       delta;
   logic             is_up;
   logic             is_down;
   logic             is_illegal;

   // Maps an AB state onto its position in the up-counting cycle
   // 00 -> 10 -> 11 -> 01, so direction falls out of a modulo-4 difference.
   function automatic logic [1:0] phase_idx(input logic [1:0] ab);
      logic [1:0] idx;
      case (ab)
         2'b00:   idx = 2'd0;
         2'b10:   idx = 2'd1;
         2'b11:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   // A candidate is accepted once it has been stable for FILT_LEN samples.
   // Before priming the first stable state is simply adopted, so the block
   // never reports a step for whatever the pins happened to show at reset.
   // A difference of 1 is one step up, 3 is one step down, 2 means both
   // phases moved at once.
   always_comb begin
      qualify    = (stable_cnt == FILT_MAX) && ((cand != filt) || !primed);
      delta      = phase_idx(cand) - phase_idx(filt);
      is_up      = qualify && primed && (delta == 2'd1);
      is_down    = qualify && primed && (delta == 2'd3);
      is_illegal = qualify && primed && (delta == 2'd2);
   end

   // Two-flop synchronizer followed by the stability filter. The stable
   // count saturates at FILT_MAX so an accepted state does not retrigger.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 2'b00;
         sync2      <= 2'b00;
         cand       <= 2'b00;
         filt       <= 2'b00;
         stable_cnt <= 4'd0;
         primed     <= 1'b0;
      end else begin
         sync1 <= {bus.enc_a, bus.enc_b};
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand       <= sync2;
            stable_cnt <= 4'd1;
         end else if (stable_cnt != FILT_MAX) begin
            stable_cnt <= stable_cnt + 4'd1;
         end
         if (qualify) begin
            filt   <= cand;
            primed <= 1'b1;
         end
      end
   end

   // Result registers. A clear wins over a same-cycle step for the position,
   // but the step pulse and direction are still reported. A new illegal
   // transition wins over a same-cycle err_clr.
   always_ff @(posedge clk) begin
      if (rst) begin
         step_q <= 1'b0;
         dir_q  <= 1'b0;
         err_q  <= 1'b0;
         pos_q  <= '0;
      end else begin
         step_q <= is_up | is_down;
         if (is_up | is_down) begin
            dir_q <= is_up;
         end
         if (bus.clr) begin
            pos_q <= '0;
         end else if (is_up) begin
            pos_q <= pos_q + POS_ONE;
         end else if (is_down) begin
            pos_q <= pos_q - POS_ONE;
         end
         if (is_illegal) begin
            err_q <= 1'b1;
         end else if (bus.err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign bus.step     = step_q;
   assign bus.dir      = dir_q;
   assign bus.position = pos_q;
   assign bus.err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder
//
// Purpose:
//    Directed, self-checking bench for quad_decoder at default parameters
//    (CNT_W=16, FILT_LEN=3). Inputs are driven and outputs sampled on the
//    falling clock edge. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_quad_decoder;

   logic clk;
   logic rst;

   int errors;
   int checks;

   // Observation counters filled by drive_hold while pins are held.
   int step_total;
   int up_total;
   int down_total;
   int first_step_at;

   quad_decoder_if #(.CNT_W(16)) bus ();

   quad_decoder #(
      .CNT_W    (16),
      .FILT_LEN (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_obs();
      step_total    = 0;
      up_total      = 0;
      down_total    = 0;
      first_step_at = 0;
   endtask

   // Sets the pins and holds them for a number of cycles, recording any
   // step pulses seen. Called at a falling edge, returns at a falling edge.
   task automatic drive_hold(input logic [1:0] ab, input int cycles);
      bus.enc_a = ab[1];
      bus.enc_b = ab[0];
      for (int i = 1; i <= cycles; i++) begin
         @(negedge clk);
         if (bus.step === 1'b1) begin
            step_total++;
            if (bus.dir === 1'b1) up_total++;
            else down_total++;
            if (first_step_at == 0) first_step_at = i;
         end
      end
   endtask

   task automatic do_reset(input logic [1:0] ab);
      rst       = 1'b1;
      bus.enc_a = ab[1];
      bus.enc_b = ab[0];
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.enc_a   = 1'b1;
      bus.enc_b   = 1'b1;
      bus.clr     = 1'b0;
      bus.err_clr = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (bus.step !== 1'b0 || bus.dir !== 1'b0 || bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: step=%b dir=%b err=%b, required 0 0 0",
                  bus.step, bus.dir, bus.err);
      end
      checks++;
      if (bus.position !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_position: got %h, required 0000", bus.position);
      end
      rst = 1'b0;
      clear_obs();
      drive_hold(2'b11, 20);
      checks++;
      if (step_total != 0) begin
         errors++;
         $display("[TB] FAIL prime_no_step: got %0d steps, required 0", step_total);
      end
      checks++;
      if (bus.err !== 1'b0 || bus.position !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL prime_state: err=%b pos=%h, required 0 0000",
                  bus.err, bus.position);
      end
   endtask

   task automatic test_up();
      logic [1:0] seq [4];
      logic [15:0] exp_pos;
      seq[0] = 2'b10;
      seq[1] = 2'b11;
      seq[2] = 2'b01;
      seq[3] = 2'b00;
      do_reset(2'b00);
      drive_hold(2'b00, 20);
      exp_pos = 16'h0000;
      for (int rep = 0; rep < 4; rep++) begin
         for (int k = 0; k < 4; k++) begin
            clear_obs();
            drive_hold(seq[k], 10);
            exp_pos = exp_pos + 16'h0001;
            checks++;
            if (step_total != 1 || up_total != 1) begin
               errors++;
               $display("[TB] FAIL up_step r%0d k%0d: steps=%0d ups=%0d, required 1 1",
                        rep, k, step_total, up_total);
            end
            checks++;
            if (first_step_at != 6) begin
               errors++;
               $display("[TB] FAIL up_latency r%0d k%0d: step at %0d, required 6",
                        rep, k, first_step_at);
            end
            checks++;
            if (bus.position !== exp_pos) begin
               errors++;
               $display("[TB] FAIL up_position r%0d k%0d: got %h, required %h",
                        rep, k, bus.position, exp_pos);
            end
         end
      end
      checks++;
      if (bus.position !== 16'd16 || bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL up_total: pos=%h err=%b, required 0010 0",
                  bus.position, bus.err);
      end
   endtask

   task automatic test_down_wrap();
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      checks++;
      if (bus.position !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL clr_position: got %h, required 0000", bus.position);
      end
      clear_obs();
      drive_hold(2'b01, 10);
      checks++;
      if (step_total != 1 || down_total != 1 || bus.dir !== 1'b0) begin
         errors++;
         $display("[TB] FAIL down_step: steps=%0d downs=%0d dir=%b, required 1 1 0",
                  step_total, down_total, bus.dir);
      end
      checks++;
      if (bus.position !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL down_wrap: got %h, required ffff", bus.position);
      end
      clear_obs();
      drive_hold(2'b00, 10);
      checks++;
      if (step_total != 1 || up_total != 1 || bus.dir !== 1'b1) begin
         errors++;
         $display("[TB] FAIL up_after_wrap: steps=%0d ups=%0d dir=%b, required 1 1 1",
                  step_total, up_total, bus.dir);
      end
      checks++;
      if (bus.position !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL up_wrap: got %h, required 0000", bus.position);
      end
   endtask

   task automatic test_glitch();
      clear_obs();
      drive_hold(2'b10, 2);
      drive_hold(2'b00, 12);
      checks++;
      if (step_total != 0) begin
         errors++;
         $display("[TB] FAIL glitch2_step: got %0d steps, required 0", step_total);
      end
      checks++;
      if (bus.position !== 16'h0000 || bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL glitch2_state: pos=%h err=%b, required 0000 0",
                  bus.position, bus.err);
      end
      clear_obs();
      drive_hold(2'b10, 3);
      drive_hold(2'b00, 15);
      checks++;
      if (step_total != 2 || up_total != 1 || down_total != 1) begin
         errors++;
         $display("[TB] FAIL glitch3_steps: steps=%0d ups=%0d downs=%0d, required 2 1 1",
                  step_total, up_total, down_total);
      end
      checks++;
      if (bus.position !== 16'h0000 || bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL glitch3_state: pos=%h err=%b, required 0000 0",
                  bus.position, bus.err);
      end
   endtask

   task automatic test_illegal();
      clear_obs();
      drive_hold(2'b11, 10);
      checks++;
      if (bus.err !== 1'b1 || step_total != 0) begin
         errors++;
         $display("[TB] FAIL illegal_err: err=%b steps=%0d, required 1 0",
                  bus.err, step_total);
      end
      checks++;
      if (bus.position !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL illegal_position: got %h, required 0000", bus.position);
      end
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      checks++;
      if (bus.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_clr: got %b, required 0", bus.err);
      end
      clear_obs();
      drive_hold(2'b01, 10);
      checks++;
      if (step_total != 1 || up_total != 1 || bus.position !== 16'h0001) begin
         errors++;
         $display("[TB] FAIL post_err_step: steps=%0d ups=%0d pos=%h, required 1 1 0001",
                  step_total, up_total, bus.position);
      end
   endtask

   task automatic test_clr_step_and_rst();
      // From AB=01 at position 1, four more up steps reach position 5.
      drive_hold(2'b00, 10);
      drive_hold(2'b10, 10);
      drive_hold(2'b11, 10);
      drive_hold(2'b01, 10);
      checks++;
      if (bus.position !== 16'h0005) begin
         errors++;
         $display("[TB] FAIL pre_clr_position: got %h, required 0005", bus.position);
      end
      // The step lands at the 6th falling edge; clr covers the edge before it.
      bus.enc_a = 1'b0;
      bus.enc_b = 1'b0;
      repeat (5) @(negedge clk);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      checks++;
      if (bus.step !== 1'b1 || bus.dir !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clr_step_pulse: step=%b dir=%b, required 1 1",
                  bus.step, bus.dir);
      end
      checks++;
      if (bus.position !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL clr_priority: got %h, required 0000", bus.position);
      end
      drive_hold(2'b00, 4);
      // Reset in the middle of a filter window with AB=10 on the pins.
      bus.enc_a = 1'b1;
      bus.enc_b = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.step !== 1'b0 || bus.dir !== 1'b0 || bus.err !== 1'b0 ||
          bus.position !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL mid_rst: step=%b dir=%b err=%b pos=%h, required 0 0 0 0000",
                  bus.step, bus.dir, bus.err, bus.position);
      end
      rst = 1'b0;
      clear_obs();
      drive_hold(2'b10, 20);
      checks++;
      if (step_total != 0 || bus.err !== 1'b0 || bus.position !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reprime: steps=%0d err=%b pos=%h, required 0 0 0000",
                  step_total, bus.err, bus.position);
      end
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      rst         = 1'b1;
      bus.enc_a   = 1'b1;
      bus.enc_b   = 1'b1;
      bus.clr     = 1'b0;
      bus.err_clr = 1'b0;
      clear_obs();
      @(negedge clk);
      test_reset();
      test_up();
      test_down_wrap();
      test_glitch();
      test_illegal();
      test_clr_step_and_rst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
